// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bus: decoded pipeline state in, register enables and
// status out. The pipeline drives the master side; the controller is the slave.
interface hazard_stall_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      instr_reg;
    logic [31:0]      instr_reg_ex;
    logic             MemRead_exe;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout;

    modport master (
        output instr_reg,
        output instr_reg_ex,
        output MemRead_exe,
        output branch_taken,
        output mem_busy,
        input  pc_write,
        input  ifid_write,
        input  ifid_flush,
        input  idex_bubble,
        input  stall_cycles,
        input  mem_timeout
    );

    modport slave (
        input  instr_reg,
        input  instr_reg_ex,
        input  MemRead_exe,
        input  branch_taken,
        input  mem_busy,
        output pc_write,
        output ifid_write,
        output ifid_flush,
        output idex_bubble,
        output stall_cycles,
        output mem_timeout
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// LEGv8 5-stage pipeline sequencer: load-use stalls, taken-branch flushes,
// memory-busy freeze, plus a stall-cycle counter and sticky memory timeout.
module hazard_stall_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus
);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              timeout_q, timeout_d;

    logic [4:0] rd_ex;
    logic       id_rtype;
    logic       id_src_rd;
    logic       load_use;
    logic       pc_write_c;
    logic       ifid_write_c;
    logic       ifid_flush_c;
    logic       idex_bubble_c;

    // Load-use detection: EX load target against every ID source register.
    always_comb begin
        rd_ex     = bus.instr_reg_ex[4:0];
        id_rtype  = (bus.instr_reg[28:24] == 5'b01010) ||
                    (bus.instr_reg[28:24] == 5'b01011);
        id_src_rd = (bus.instr_reg[31:21] == 11'b11111000000) ||
                    (bus.instr_reg[31:24] == 8'b10110100);
        load_use  = bus.MemRead_exe && (rd_ex != 5'd31) &&
                    ((rd_ex == bus.instr_reg[9:5]) ||
                     (id_rtype  && (rd_ex == bus.instr_reg[20:16])) ||
                     (id_src_rd && (rd_ex == bus.instr_reg[4:0])));
    end

    // Next state and enables; MEM_WAIT on release behaves exactly like RUN.
    always_comb begin
        state_d       = state_q;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;

        if (reset) begin
            state_d       = RUN;
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
        end else if (bus.mem_busy) begin
            state_d       = MEM_WAIT;
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
        end else begin
            unique case (state_q)
                RUN, MEM_WAIT: begin
                    if (bus.branch_taken) begin
                        state_d       = FLUSH;
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                    end else if (load_use) begin
                        state_d       = LD_STALL;
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_bubble_c = 1'b1;
                    end else begin
                        state_d       = RUN;
                    end
                end
                LD_STALL, FLUSH: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Counters and sticky timeout flag.
    always_comb begin
        wait_d    = wait_q;
        stall_d   = stall_q;
        timeout_d = timeout_q;

        if (reset) begin
            wait_d    = '0;
            stall_d   = '0;
            timeout_d = 1'b0;
        end else begin
            if (bus.mem_busy) begin
                wait_d = (wait_q == WAIT_SAT) ? WAIT_SAT : wait_q + WAIT_W'(1);
            end else begin
                wait_d = '0;
            end
            if (wait_d > WAIT_LIM) begin
                timeout_d = 1'b1;
            end
            if (!pc_write_c && (stall_q != CNT_MAX)) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_write     = pc_write_c;
    assign bus.ifid_write   = ifid_write_c;
    assign bus.ifid_flush   = ifid_flush_c;
    assign bus.idex_bubble  = idex_bubble_c;
    assign bus.stall_cycles = stall_q;
    assign bus.mem_timeout  = timeout_q;

    // Immediate/address fields that never name a register.
    logic unused_fields;
    assign unused_fields = ^{bus.instr_reg[15:10], bus.instr_reg_ex[31:5]};
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencer that decides when the 5-stage LEGv8 pipeline advances, stalls or flushes. It detects load-use hazards that forwarding cannot cover, squashes wrong-path fetches on taken branches, and freezes the pipe while data memory is busy. It sits beside the forwarding logic and drives the PC, IF/ID and ID/EX register enables. It also keeps a stall-cycle performance counter and a memory-timeout flag.

Parameters:
CNT_W, 16, width of stall_cycles counter (saturating)
MAX_WAIT, 15, consecutive mem_busy cycles after which mem_timeout sets (1..255)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous active-high reset
instr_reg  input  32  instruction in ID stage (IF/ID register)
instr_reg_ex  input  32  instruction in EX stage (ID/EX register)
MemRead_exe  input  1  EX-stage instruction reads data memory
branch_taken  input  1  branch/CBZ/B/BR in EX resolved taken this cycle
mem_busy  input  1  data memory not ready; whole pipe must hold
pc_write  output  1  PC register enable
ifid_write  output  1  IF/ID register enable
ifid_flush  output  1  load NOP into IF/ID on next edge
idex_bubble  output  1  load zero controls into ID/EX on next edge
stall_cycles  output  CNT_W  count of cycles with pc_write=0 (saturates at all-ones)
mem_timeout  output  1  sticky: mem_busy held > MAX_WAIT consecutive cycles

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=RUN, stall_cycles=0, mem_timeout=0, wait counter=0. While reset is high, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1. Reset mid-stall abandons the stall with no further bubble.
- States: RUN, LD_STALL, FLUSH, MEM_WAIT. Outputs are combinational from state and inputs. Only state, the counters and the flag are registered.
- load_use (combinational) = MemRead_exe & instr_reg_ex[4:0]!=31 & (rd_ex==instr_reg[9:5] | (id_rtype & rd_ex==instr_reg[20:16]) | (id_src_rd & rd_ex==instr_reg[4:0])).
  - rd_ex = instr_reg_ex[4:0].
  - id_rtype = instr_reg[28:24] is 5'b01010 or 5'b01011.
  - id_src_rd = instr_reg[31:21]==11'b11111000000 (STUR) or instr_reg[31:24]==8'b10110100 (CBZ).
- Event priority, highest first: mem_busy > branch_taken > load_use.
- RUN:
  - mem_busy: pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0; next MEM_WAIT.
  - else branch_taken: pc_write=1, ifid_flush=1, idex_bubble=1; next FLUSH.
  - else load_use: pc_write=0, ifid_write=0, idex_bubble=1; next LD_STALL.
  - else: pc_write=1, ifid_write=1, flush/bubble=0; stay RUN.
- LD_STALL: lasts exactly one cycle; outputs normal (advance). load_use is not re-evaluated. mem_busy takes priority (go to MEM_WAIT, hold); otherwise next RUN.
- FLUSH: one cycle; outputs normal (advance). branch_taken is ignored (wrong-path instruction already squashed). mem_busy goes to MEM_WAIT; otherwise next RUN.
- MEM_WAIT: all enables 0, no bubble, no flush, while mem_busy=1. Wait counter increments, saturating at MAX_WAIT+1. When it exceeds MAX_WAIT, mem_timeout sets and stays set until reset. When mem_busy=0: outputs as in RUN for the current inputs (same priorities), wait counter clears, next state chosen as from RUN.
- A load-use hazard pending before mem_busy is re-detected after MEM_WAIT, because instructions were held in place.
- stall_cycles increments on every non-reset cycle with pc_write=0 and saturates at 2^CNT_W-1.
- Load-use latency: exactly one bubble cycle per hazard. Branch penalty: exactly one flushed slot.

Test Plan:
- Load-use: EX=LDUR X2 (MemRead_exe=1), ID=ADD X3,X2,X4. Required: cycle 0 pc_write=0, ifid_write=0, idex_bubble=1; cycle 1 all advance; stall_cycles=1.
- No false stall: EX=LDUR XZR (rd=31), ID=ADD X3,X31,X4. Required: pc_write=1, no bubble. Repeat with ID=ADDI (I-type) where [20:16] matches rd_ex: also no stall.
- STUR source: EX=LDUR X5, ID=STUR X5,[X1,#0]. Required: one bubble. With ID=CBZ X5: one bubble.
- Branch: branch_taken=1 for one cycle in RUN. Required: ifid_flush=1 and idex_bubble=1 that cycle; next cycle normal; branch_taken asserted again in FLUSH is ignored.
- Simultaneous events: mem_busy=1 for 3 cycles together with branch_taken=1 and load_use. Required: hold for 3 cycles (stall_cycles=3); on release, branch flush wins; no bubble is dropped or duplicated.
- Timeout/reset: mem_busy held 16 cycles with MAX_WAIT=15. Required: mem_timeout=1 from the 17th cycle. Then reset asserted in MEM_WAIT: state=RUN, mem_timeout=0, stall_cycles=0 after the edge.
